// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             redirect_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             err_clr,
    output logic             pc_adv,
    output logic             if_id_adv,
    output logic             id_ex_adv,
    output logic             ex_mem_adv,
    output logic             mem_wb_adv,
    output logic             if_id_clr,
    output logic             id_ex_clr,
    output logic             ex_mem_clr,
    output logic             mem_wb_clr,
    output logic             dmem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);

    typedef enum logic {RUN = 1'b0, MWAIT = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WW-1:0]    r_wait_cnt;
    logic [WW-1:0]    w_wait_nxt;
    logic             r_dmem_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_mem_wait;
    logic             w_timeout;
    logic             w_load_use;

    assign w_timeout  = (r_state == MWAIT) && (r_wait_cnt == LAST) && !dmem_ready;
    assign w_mem_wait = ((r_state == RUN) && dmem_req && !dmem_ready) ||
                        ((r_state == MWAIT) && !dmem_ready && (r_wait_cnt != LAST));
    assign w_load_use = ex_memread && (ex_rt != 5'd0) &&
                        ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        pc_adv      = 1'b1;
        if_id_adv   = 1'b1;
        id_ex_adv   = 1'b1;
        ex_mem_adv  = 1'b1;
        mem_wb_adv  = 1'b1;
        if_id_clr   = 1'b0;
        id_ex_clr   = 1'b0;
        ex_mem_clr  = 1'b0;
        mem_wb_clr  = 1'b0;

        case (r_state)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    w_state_nxt = MWAIT;
                    w_wait_nxt  = WW'(1);
                end
            end
            MWAIT: begin
                if (dmem_ready || (r_wait_cnt == LAST)) begin
                    w_state_nxt = RUN;
                    w_wait_nxt  = '0;
                end else begin
                    w_wait_nxt  = r_wait_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_wait_nxt  = '0;
            end
        endcase

        // Held-in-reset pipeline sees the idle pattern regardless of the inputs
        if (!rst) begin
            pc_adv = 1'b1;
        end else if (w_mem_wait) begin
            pc_adv     = 1'b0;
            if_id_adv  = 1'b0;
            id_ex_adv  = 1'b0;
            ex_mem_adv = 1'b0;
            mem_wb_clr = 1'b1;
        end else if (w_timeout) begin
            pc_adv     = 1'b0;
            if_id_adv  = 1'b0;
            id_ex_adv  = 1'b0;
            ex_mem_clr = 1'b1;
            mem_wb_clr = 1'b1;
        end else if (redirect_ex) begin
            if_id_clr = 1'b1;
            id_ex_clr = 1'b1;
        end else if (w_load_use) begin
            pc_adv    = 1'b0;
            if_id_adv = 1'b0;
            id_ex_clr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_dmem_err  <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_timeout) begin
                r_dmem_err <= 1'b1;
            end else if (err_clr) begin
                r_dmem_err <= 1'b0;
            end
            if (!pc_adv && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (if_id_clr && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign dmem_err  = r_dmem_err;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam logic [1:0] H = 2'd0;
    localparam logic [1:0] L = 2'd1;
    localparam logic [1:0] B = 2'd2;
    localparam logic [9:0] A_NORM = {L, L, L, L, L};
    localparam logic [9:0] A_LU   = {H, H, B, L, L};
    localparam logic [9:0] A_RED  = {L, B, B, L, L};
    localparam logic [9:0] A_MW   = {H, H, H, H, B};
    localparam logic [9:0] A_TO   = {H, H, H, B, B};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_rs = 0, id_uses_rt = 0, ex_memread = 0;
    logic       redirect_ex = 0, dmem_req = 0, dmem_ready = 0, err_clr = 0;
    logic       pc_adv, if_id_adv, id_ex_adv, ex_mem_adv, mem_wb_adv;
    logic       if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr, dmem_err;
    logic [1:0] stall_cnt, flush_cnt;
    logic [9:0] w_act;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .redirect_ex(redirect_ex),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .err_clr(err_clr),
        .pc_adv(pc_adv), .if_id_adv(if_id_adv), .id_ex_adv(id_ex_adv),
        .ex_mem_adv(ex_mem_adv), .mem_wb_adv(mem_wb_adv),
        .if_id_clr(if_id_clr), .id_ex_clr(id_ex_clr), .ex_mem_clr(ex_mem_clr),
        .mem_wb_clr(mem_wb_clr), .dmem_err(dmem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Per-stage action: hold / load / bubble
    function automatic logic [1:0] enc(input logic adv, input logic clr);
        return clr ? B : (adv ? L : H);
    endfunction

    assign w_act = {enc(pc_adv, 1'b0), enc(if_id_adv, if_id_clr), enc(id_ex_adv, id_ex_clr),
                    enc(ex_mem_adv, ex_mem_clr), enc(mem_wb_adv, mem_wb_clr)};

    typedef struct {
        logic [4:0] rs, rt, ert;
        logic       urs, urt, mr, red, req, rdy;
        logic [9:0] act;
        logic [1:0] sc, fc;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                                input logic urt, input logic mr, input logic [4:0] ert,
                                input logic red, input logic req, input logic rdy,
                                input logic [9:0] act, input logic [1:0] sc, input logic [1:0] fc);
        vec_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mr = mr; v.ert = ert;
        v.red = red; v.req = req; v.rdy = rdy; v.act = act; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
        ex_memread = v.mr; ex_rt = v.ert; redirect_ex = v.red;
        dmem_req = v.req; dmem_ready = v.rdy;
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic mr, input logic [4:0] ert,
                          input logic red, input logic req, input logic rdy);
        drive(mk(rs, rt, urs, urt, mr, ert, red, req, rdy, A_NORM, 2'd0, 2'd0));
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    // Called at posedge+1 with inputs set: check actions, then move to next posedge+1
    task automatic cyc(input string nm, input logic [9:0] exp);
        #1;
        chk(nm, {22'd0, w_act}, {22'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, A_NORM, 2'd0, 2'd0);
        tbl[1]  = mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, A_LU,   2'd1, 2'd0);
        tbl[2]  = mk(5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0, A_NORM, 2'd0, 2'd0);
        tbl[3]  = mk(5'd3, 5'd7, 1, 1, 1, 5'd7, 0, 0, 0, A_LU,   2'd1, 2'd0);
        tbl[4]  = mk(5'd5, 5'd0, 0, 1, 1, 5'd5, 0, 0, 0, A_NORM, 2'd0, 2'd0);
        tbl[5]  = mk(5'd5, 5'd5, 1, 1, 0, 5'd5, 0, 0, 0, A_NORM, 2'd0, 2'd0);
        tbl[6]  = mk(5'd1, 5'd2, 1, 1, 0, 5'd0, 1, 0, 0, A_RED,  2'd0, 2'd1);
        tbl[7]  = mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, A_RED,  2'd0, 2'd1);
        tbl[8]  = mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 1, 1, A_LU,   2'd1, 2'd0);
        tbl[9]  = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0, A_MW,   2'd1, 2'd0);
        tbl[10] = mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 1, 0, A_MW,   2'd1, 2'd0);

        #2;
        chk("rst_act", {22'd0, w_act}, {22'd0, A_NORM});
        chk("rst_cnt", {28'd0, stall_cnt, flush_cnt}, 32'd0);
        chk("rst_err", {31'd0, dmem_err}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
            do_reset();
            drive(tbl[i]);
            #1;
            chk($sformatf("vec%0d_act", i), {22'd0, w_act}, {22'd0, tbl[i].act});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_cnt", i), {28'd0, stall_cnt, flush_cnt},
                {28'd0, tbl[i].sc, tbl[i].fc});
        end

        // Load-use: one bubble, then the load has moved on
        @(posedge clk); #1; do_reset();
        set_in(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0);
        cyc("lu", A_LU);
        set_in(5'd5, 5'd0, 1, 0, 0, 5'd5, 0, 0, 0);
        cyc("lu_next", A_NORM);
        chk("lu_cnt", {28'd0, stall_cnt, flush_cnt}, {28'd0, 2'd1, 2'd0});

        // Redirect beats load-use
        do_reset();
        set_in(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0);
        cyc("red_lu", A_RED);
        set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
        cyc("red_lu_next", A_NORM);
        chk("red_lu_cnt", {28'd0, stall_cnt, flush_cnt}, {28'd0, 2'd0, 2'd1});

        // Three-cycle memory wait, then completion
        do_reset();
        set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
        cyc("mw1", A_MW);
        cyc("mw2", A_MW);
        cyc("mw3", A_MW);
        dmem_ready = 1'b1;
        cyc("mw_done", A_NORM);
        chk("mw_stall", {30'd0, stall_cnt}, 32'd3);
        dmem_req = 1'b0; dmem_ready = 1'b0;
        cyc("mw_run", A_NORM);

        // Timeout on wait cycle 4, sticky error, err_clr
        do_reset();
        set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
        cyc("to1", A_MW);
        cyc("to2", A_MW);
        cyc("to3", A_MW);
        chk("to_err_pre", {31'd0, dmem_err}, 32'd0);
        cyc("to4", A_TO);
        chk("to_err_set", {31'd0, dmem_err}, 32'd1);
        dmem_req = 1'b0;
        cyc("to_after", A_NORM);
        chk("to_err_hold", {31'd0, dmem_err}, 32'd1);
        err_clr = 1'b1;
        cyc("to_clr", A_NORM);
        err_clr = 1'b0;
        chk("to_err_clr", {31'd0, dmem_err}, 32'd0);
        chk("to_stall_sat", {30'd0, stall_cnt}, 32'd3);

        // Timeout wins over err_clr, then async reset mid-wait
        do_reset();
        err_clr = 1'b1;
        set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
        cyc("tc1", A_MW);
        cyc("tc2", A_MW);
        cyc("tc3", A_MW);
        cyc("tc4", A_TO);
        err_clr = 1'b0;
        chk("to_vs_clr", {31'd0, dmem_err}, 32'd1);
        cyc("rw1", A_MW);
        #3;
        rst = 1'b0;
        #1;
        chk("rw_rst_act", {22'd0, w_act}, {22'd0, A_NORM});
        chk("rw_rst_cnt", {28'd0, stall_cnt, flush_cnt}, 32'd0);
        chk("rw_rst_err", {31'd0, dmem_err}, 32'd0);
        rst = 1'b1;
        cyc("rr1", A_MW);
        cyc("rr2", A_MW);
        cyc("rr3", A_MW);
        cyc("rr4", A_TO);

        // Redirect during wait takes effect only on completion
        dmem_req = 1'b0;
        do_reset();
        set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0);
        cyc("rdw1", A_MW);
        cyc("rdw2", A_MW);
        dmem_ready = 1'b1;
        cyc("rdw_done", A_RED);
        chk("rdw_cnt", {28'd0, stall_cnt, flush_cnt}, {28'd0, 2'd2, 2'd1});

        // Counter saturation at 3 with CNT_W = 2
        do_reset();
        set_in(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc($sformatf("sat_lu%0d", k), A_LU);
        chk("sat_stall", {30'd0, stall_cnt}, 32'd3);
        redirect_ex = 1'b1;
        for (int k = 0; k < 5; k++) cyc($sformatf("sat_red%0d", k), A_RED);
        chk("sat_cnt", {28'd0, stall_cnt, flush_cnt}, {28'd0, 2'd3, 2'd3});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Drives the advance (load enable) and clear inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects three conditions:
  - load-use hazards between the EX and ID stages;
  - control redirects resolved in EX;
  - multi-cycle data-memory waits in the MEM stage, with a timeout.
- Also keeps saturating performance counters.

Parameters:
- TIMEOUT, 64, maximum consecutive dmem wait cycles before the access is aborted (≥2).
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- id_rs, id_rt  input  5 each  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  input  1 each  the ID instruction actually reads that source.
- ex_memread  input  1  the instruction in EX is a load.
- ex_rt  input  5  destination of the load in EX.
- redirect_ex  input  1  the branch/jump in EX was taken; PC loads its target.
- dmem_req  input  1  the instruction in MEM accesses data memory.
- dmem_ready  input  1  data memory completes the access this cycle.
- err_clr  input  1  clears dmem_err.
- pc_adv, if_id_adv, id_ex_adv, ex_mem_adv, mem_wb_adv  output  1 each  1 = register loads next value, 0 = holds.
- if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr  output  1 each  1 = register loads a bubble (all zero).
- dmem_err  output  1  sticky timeout flag.
- stall_cnt  output  CNT_W  cycles in which pc_adv = 0.
- flush_cnt  output  CNT_W  cycles in which if_id_clr = 1.

Behaviour:
- Reset (rst = 0, async):
  - state = RUN, wait_cnt = 0, dmem_err = 0, stall_cnt = 0, flush_cnt = 0.
  - All *_adv = 1, all *_clr = 0 (driven from state and inputs).
- State machine, 2 states:
  - RUN → MWAIT when dmem_req = 1 and dmem_ready = 0; wait_cnt ← 1.
  - MWAIT → RUN when dmem_ready = 1, or when wait_cnt = TIMEOUT−1 (timeout); wait_cnt ← 0.
  - MWAIT otherwise stays; wait_cnt increments.
- Outputs are combinational from state and inputs. Priority, highest first:
  1. Memory wait: (RUN and dmem_req = 1 and dmem_ready = 0) or (MWAIT and dmem_ready = 0 and no timeout).
     - pc_adv = if_id_adv = id_ex_adv = ex_mem_adv = 0.
     - mem_wb_clr = 1.
     - redirect_ex and load-use are ignored; they are re-evaluated after the wait.
  2. Timeout cycle: MWAIT, wait_cnt = TIMEOUT−1, dmem_ready = 0.
     - ex_mem_clr = 1 and mem_wb_clr = 1; the access is dropped.
     - PC, IF/ID and ID/EX hold.
     - dmem_err ← 1 on the following edge.
  3. Redirect: redirect_ex = 1.
     - if_id_clr = 1, id_ex_clr = 1.
     - pc_adv = 1; PC takes the target.
     - Wins over load-use because the ID instruction is wrong-path.
  4. Load-use: ex_memread = 1, ex_rt ≠ 0, and ((id_uses_rs and id_rs = ex_rt) or (id_uses_rt and id_rt = ex_rt)).
     - pc_adv = 0, if_id_adv = 0, id_ex_clr = 1.
     - EX/MEM and MEM/WB advance.
     - Exactly one bubble: next cycle the load is in MEM and the condition is no longer true.
  5. Otherwise: all *_adv = 1, all *_clr = 0.
- Rules common to all cases:
  - A *_clr = 1 overrides the matching *_adv.
  - MWAIT completion cycle (dmem_ready = 1) behaves as RUN; priorities 3–5 apply in that same cycle.
- dmem_err:
  - Set on the timeout edge; otherwise holds.
  - err_clr = 1 clears it; a timeout in the same cycle wins (stays 1).
- Counters:
  - stall_cnt += 1 on each edge where pc_adv = 0.
  - flush_cnt += 1 on each edge where if_id_clr = 1.
  - Both saturate at 2^CNT_W − 1; no wrap.
- Reset mid-wait: returns to RUN immediately; the pending access is forgotten.

Test Plan:
- Load-use: ex_memread = 1, ex_rt = 5, id_rs = 5, id_uses_rs = 1.
  - Exactly 1 cycle of pc_adv = 0, if_id_adv = 0, id_ex_clr = 1; stall_cnt = 1.
  - The same case with ex_rt = 0 gives no stall.
- Redirect and load-use together: redirect_ex = 1 while load-use is also true.
  - if_id_clr = id_ex_clr = 1 and pc_adv = 1; flush_cnt = 1, stall_cnt = 0.
- Memory wait: dmem_req = 1, dmem_ready low for 3 cycles, then high.
  - 3 cycles of front-stage adv = 0 with mem_wb_clr = 1; 4th cycle all adv = 1.
  - stall_cnt = 3; state back to RUN.
- Timeout: TIMEOUT = 4, dmem_ready held at 0.
  - Abort on wait cycle 4 with ex_mem_clr = mem_wb_clr = 1; dmem_err = 1 next cycle.
  - err_clr pulse returns dmem_err to 0.
- Redirect during wait: redirect_ex = 1 while in MWAIT.
  - No flush until the cycle dmem_ready = 1; in that cycle if_id_clr = id_ex_clr = 1.
- Reset and saturation:
  - rst low mid-MWAIT gives all adv = 1, counters 0, dmem_err = 0 asynchronously.
  - With CNT_W = 2, 5 stall cycles give stall_cnt = 3.
